// File: rtl/spidergon_traffic_injector.sv
// Per-node wormhole packet source: emits head/body/tail flits into the local router port. Registered outputs, 1-cycle start latency.
// Backpressure: per-VC credit counters; a packet with zero credits on its VC stalls with bubbles until a credit returns.
module spidergon_traffic_injector #(
  parameter int NUM_OF_NODES            = 8,
  parameter int FLIT_DATA_WIDTH         = 16,
  parameter int NODE_BUFFER_WIDTH       = 32,
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int NODE_ID                 = 0,
  parameter int PACKET_LENGTH           = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int VW = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] credit_in,
  output logic                               flit_valid,
  output logic [1:0]                         flit_type,
  output logic [VW-1:0]                      flit_vc,
  output logic [FLIT_DATA_WIDTH-1:0]         flit_data,
  output logic                               busy,
  output logic [15:0]                        pkt_count,
  output logic                               credit_err
);
  localparam int NV      = NUM_OF_VIRTUAL_CHANNELS;
  localparam int AW      = $clog2(NUM_OF_NODES);
  localparam int CREDITS = NODE_BUFFER_WIDTH / FLIT_DATA_WIDTH;
  localparam int CW      = $clog2(CREDITS + 1);
  localparam int RW      = (PACKET_LENGTH > 1) ? $clog2(PACKET_LENGTH) : 1;
  localparam int UW      = FLIT_DATA_WIDTH - 2 * AW;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HEAD_TAIL = 2'b11;
  localparam logic [AW-1:0] SELF = AW'(NODE_ID);
  localparam logic [AW-1:0] NEXT = AW'((NODE_ID + 1) % NUM_OF_NODES);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt [NV];
  logic [VW-1:0]              rr_ptr, cur_vc, pick, idx, send_vc;
  logic [15:0]                lfsr, lfsr_next;
  logic [RW-1:0]              remaining;
  logic [FLIT_DATA_WIDTH-1:0] seq, head_data, body_data;
  logic [AW-1:0]              dest;
  logic                       found, start, send_body, send;

  // First VC with credit, searching upward from rr_ptr with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NV; i++) begin
      idx = VW'((int'(rr_ptr) + i) % NV);
      if (!found && cnt[idx] != '0) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign dest      = (lfsr[AW-1:0] == SELF) ? NEXT : lfsr[AW-1:0];
  assign head_data = {seq[UW-1:0], SELF, dest};
  // Flit index k = PACKET_LENGTH - remaining, taken before the decrement.
  assign body_data = seq * FLIT_DATA_WIDTH'(PACKET_LENGTH)
                   + (FLIT_DATA_WIDTH'(PACKET_LENGTH) - FLIT_DATA_WIDTH'(remaining));

  assign start     = (state == IDLE) && en && found;
  assign send_body = (state == SEND) && (cnt[cur_vc] != '0);
  assign send      = start || send_body;
  assign send_vc   = (state == IDLE) ? pick : cur_vc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      for (int v = 0; v < NV; v++) cnt[v] <= FULL;
      rr_ptr     <= '0;
      cur_vc     <= '0;
      lfsr       <= LFSR_SEED;
      remaining  <= '0;
      seq        <= '0;
      flit_valid <= 1'b0;
      flit_type  <= '0;
      flit_vc    <= '0;
      flit_data  <= '0;
      busy       <= 1'b0;
      pkt_count  <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NV; v++) begin
        if (send && send_vc == VW'(v) && !credit_in[v]) begin
          cnt[v] <= cnt[v] - CW'(1);
        end else if (!(send && send_vc == VW'(v)) && credit_in[v]) begin
          if (cnt[v] == FULL) credit_err <= 1'b1;
          else                cnt[v]     <= cnt[v] + CW'(1);
        end
      end
      flit_valid <= send;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            flit_vc   <= pick;
            flit_data <= head_data;
            rr_ptr    <= VW'((int'(pick) + 1) % NV);
            lfsr      <= lfsr_next;
            if (PACKET_LENGTH == 1) begin
              flit_type <= T_HEAD_TAIL;
              pkt_count <= pkt_count + 16'd1;
              seq       <= seq + FLIT_DATA_WIDTH'(1);
            end else begin
              flit_type <= T_HEAD;
              state     <= SEND;
              remaining <= RW'(PACKET_LENGTH - 1);
              cur_vc    <= pick;
              busy      <= 1'b1;
            end
          end
        end
        SEND: begin
          // busy stays up through the tail cycle and drops after it.
          busy <= 1'b1;
          if (send_body) begin
            flit_vc   <= cur_vc;
            flit_data <= body_data;
            remaining <= remaining - RW'(1);
            if (remaining == RW'(1)) begin
              flit_type <= T_TAIL;
              state     <= IDLE;
              pkt_count <= pkt_count + 16'd1;
              seq       <= seq + FLIT_DATA_WIDTH'(1);
            end else begin
              flit_type <= T_BODY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spidergon_traffic_injector.sv
// Bench for spidergon_traffic_injector: scoreboard of expected flits plus a vector table for round robin.
module tb_spidergon_traffic_injector;
  typedef struct packed {logic [1:0] typ; logic vc; logic [15:0] data;} flit_t;
  typedef struct {logic en; logic [1:0] typ; logic vc; logic [15:0] data;} vec_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic rst_a, rst_b, en_a, en_b;
  logic [1:0] cr_a, cr_b, ft_a, ft_b;
  logic fv_a, fv_b, fvc_a, fvc_b, busy_a, busy_b, ce_a, ce_b;
  logic [15:0] fd_a, fd_b, pc_a, pc_b;

  int checks = 0, fails = 0, cyc = 0;
  flit_t exp_a[$], exp_b[$], cap_a[$];
  int cap_cyc_a[$];
  int heads_a, heads_b, bad_dest_b;
  logic [15:0] first_head_b, last_head_b;
  logic [15:0] lfsr_m[2], seq_m[2];
  logic rr_m[2];
  int dly_a, dly_b;
  logic [1:0] mask_a, mask_b, man_a, man_b;
  logic [1:0] pipe_a[4], pipe_b[4];
  vec_t tbl[12];

  spidergon_traffic_injector #(.NODE_ID(0), .LFSR_SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .credit_in(cr_a), .flit_valid(fv_a), .flit_type(ft_a),
    .flit_vc(fvc_a), .flit_data(fd_a), .busy(busy_a), .pkt_count(pc_a), .credit_err(ce_a));

  spidergon_traffic_injector #(.NODE_ID(1), .LFSR_SEED(16'h0001)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .credit_in(cr_b), .flit_valid(fv_b), .flit_type(ft_b),
    .flit_vc(fvc_b), .flit_data(fd_b), .busy(busy_b), .pkt_count(pc_b), .credit_err(ce_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset(input int w);
    lfsr_m[w] = (w == 0) ? 16'hACE1 : 16'h0001;
    seq_m[w]  = '0;
    rr_m[w]   = 1'b0;
    if (w == 0) begin
      exp_a.delete(); cap_a.delete(); cap_cyc_a.delete(); heads_a = 0;
    end else begin
      exp_b.delete(); heads_b = 0; bad_dest_b = 0;
    end
  endtask

  // Expected flits of n packets, assuming credit is always present on the round-robin VC at start.
  task automatic push_pkts(input int w, input int n);
    flit_t f;
    logic [2:0] node, dest;
    node = 3'(w);
    for (int p = 0; p < n; p++) begin
      dest = lfsr_m[w][2:0];
      if (dest == node) dest = node + 3'd1;
      f.typ = 2'b01; f.vc = rr_m[w]; f.data = {seq_m[w][9:0], node, dest};
      if (w == 0) exp_a.push_back(f); else exp_b.push_back(f);
      for (int k = 1; k < 4; k++) begin
        f.typ  = (k == 3) ? 2'b10 : 2'b00;
        f.data = seq_m[w] * 16'd4 + 16'(k);
        if (w == 0) exp_a.push_back(f); else exp_b.push_back(f);
      end
      rr_m[w]   = ~rr_m[w];
      lfsr_m[w] = lfsr_step(lfsr_m[w]);
      seq_m[w]  = seq_m[w] + 16'd1;
    end
  endtask

  task automatic reset_a();
    @(posedge clk); #2 rst_a = 1'b1; man_a = 2'b00;
    @(posedge clk); #2 model_reset(0); rst_a = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream sink: returns one credit per received flit after dly cycles, plus manual pulses.
  initial begin
    for (int i = 0; i < 4; i++) begin pipe_a[i] = 2'b00; pipe_b[i] = 2'b00; end
    forever begin
      @(negedge clk);
      for (int i = 3; i > 0; i--) begin pipe_a[i] = pipe_a[i-1]; pipe_b[i] = pipe_b[i-1]; end
      pipe_a[0] = (fv_a && mask_a[fvc_a]) ? (2'b01 << fvc_a) : 2'b00;
      pipe_b[0] = (fv_b && mask_b[fvc_b]) ? (2'b01 << fvc_b) : 2'b00;
      if (rst_a) for (int i = 0; i < 4; i++) pipe_a[i] = 2'b00;
      if (rst_b) for (int i = 0; i < 4; i++) pipe_b[i] = 2'b00;
      cr_a = pipe_a[dly_a] | man_a;
      cr_b = pipe_b[dly_b] | man_b;
    end
  end

  initial forever begin
    flit_t got, e;
    @(negedge clk);
    if (fv_a) begin
      got = {ft_a, fvc_a, fd_a};
      cap_a.push_back(got);
      cap_cyc_a.push_back(cyc);
      if (ft_a[0]) heads_a++;
      if (exp_a.size() == 0) begin
        checks++; fails++;
        $display("FAIL sb_a unexpected flit actual=%h required=none", got);
      end else begin
        e = exp_a.pop_front();
        check("sb_a_flit", 32'(got), 32'(e));
      end
    end
    if (fv_b) begin
      got = {ft_b, fvc_b, fd_b};
      if (ft_b[0]) begin
        if (heads_b == 0) first_head_b = fd_b;
        last_head_b = fd_b;
        if (fd_b[2:0] == 3'd1) bad_dest_b++;
        heads_b++;
      end
      if (exp_b.size() == 0) begin
        checks++; fails++;
        $display("FAIL sb_b unexpected flit actual=%h required=none", got);
      end else begin
        e = exp_b.pop_front();
        check("sb_b_flit", 32'(got), 32'(e));
      end
    end
  end

  initial begin
    int t0, n;
    tbl[0]  = '{1'b1, 2'b01, 1'b0, 16'h0001}; tbl[1]  = '{1'b1, 2'b00, 1'b0, 16'd1};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 16'd2};    tbl[3]  = '{1'b1, 2'b10, 1'b0, 16'd3};
    tbl[4]  = '{1'b1, 2'b01, 1'b1, 16'h0043}; tbl[5]  = '{1'b1, 2'b00, 1'b1, 16'd5};
    tbl[6]  = '{1'b1, 2'b00, 1'b1, 16'd6};    tbl[7]  = '{1'b1, 2'b10, 1'b1, 16'd7};
    tbl[8]  = '{1'b1, 2'b01, 1'b0, 16'h0087}; tbl[9]  = '{1'b1, 2'b00, 1'b0, 16'd9};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 16'd10};   tbl[11] = '{1'b1, 2'b10, 1'b0, 16'd11};
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0; man_a = 2'b00; man_b = 2'b00;
    mask_a = 2'b11; mask_b = 2'b11; dly_a = 0; dly_b = 0; cr_a = 2'b00; cr_b = 2'b00;
    model_reset(0); model_reset(1);
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", fv_a, 0); check("rst_type", ft_a, 0); check("rst_vc", fvc_a, 0);
    check("rst_data", fd_a, 0); check("rst_busy", busy_a, 0); check("rst_pkt_count", pc_a, 0);
    check("rst_credit_err", ce_a, 0); check("rst_valid_b", fv_b, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    n = 0;
    repeat (10) begin @(negedge clk); if (fv_a) n++; end
    check("idle_no_flit", n, 0);

    // Single packet, credits returned two cycles after each flit
    dly_a = 2; push_pkts(0, 1);
    @(posedge clk); #2 t0 = cyc; en_a = 1'b1;
    @(posedge clk); #2 en_a = 1'b0;
    for (int i = 0; i < 60 && pc_a != 16'd1; i++) @(posedge clk);
    #2;
    check("sp_pkt_count", pc_a, 1);
    check("sp_flits", cap_a.size(), 4);
    check("sp_head_latency", (cap_cyc_a.size() > 0) ? cap_cyc_a[0] : -1, t0 + 1);
    check("sp_sb_empty", exp_a.size(), 0);
    repeat (3) @(posedge clk);
    #2 check("sp_busy_low", busy_a, 0);

    // Asynchronous reset in the middle of a packet
    push_pkts(0, 1);
    @(posedge clk); #2 en_a = 1'b1;
    @(posedge clk); #2 en_a = 1'b0;
    check("ar_busy_before", busy_a, 1);
    #1 rst_a = 1'b1;
    #1;
    check("ar_valid", fv_a, 0); check("ar_type", ft_a, 0); check("ar_vc", fvc_a, 0);
    check("ar_data", fd_a, 0); check("ar_busy", busy_a, 0); check("ar_pkt_count", pc_a, 0);
    @(posedge clk); #2 model_reset(0); rst_a = 1'b0;

    // Credit starvation, then a single returned credit
    mask_a = 2'b00; dly_a = 0; push_pkts(0, 1);
    @(posedge clk); #2 en_a = 1'b1;
    @(posedge clk); #2 en_a = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("st_flits", cap_a.size(), 2); check("st_valid_low", fv_a, 0); check("st_busy", busy_a, 1);
    t0 = cyc; man_a = 2'b01;
    @(posedge clk); #2 man_a = 2'b00;
    repeat (10) @(posedge clk);
    #2;
    check("st_one_more", cap_a.size(), 3);
    check("st_latency", (cap_cyc_a.size() > 2) ? cap_cyc_a[2] : -1, t0 + 2);
    check("st_busy_hold", busy_a, 1);
    reset_a();

    // Credit returned to a full VC1
    check("ce_clear", ce_a, 0);
    mask_a = 2'b01; man_a = 2'b10;
    @(posedge clk); #2 man_a = 2'b00;
    @(posedge clk); #2 check("ce_set", ce_a, 1);
    push_pkts(0, 2); en_a = 1'b1;
    for (int i = 0; i < 100 && heads_a < 2; i++) @(posedge clk);
    #2 en_a = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    n = 0;
    foreach (cap_a[i]) if (cap_a[i].vc) n++;
    check("ce_vc1_flits", n, 2); check("ce_pkt_count", pc_a, 1); check("ce_sticky", ce_a, 1);
    reset_a();

    // Round robin, en held, prompt credit return
    mask_a = 2'b11; dly_a = 0; push_pkts(0, 3);
    en_a = tbl[0].en;
    for (int i = 0; i < 100 && heads_a < 3; i++) @(posedge clk);
    #2 en_a = 1'b0;
    for (int i = 0; i < 100 && pc_a != 16'd3; i++) @(posedge clk);
    #2;
    check("rr_count", cap_a.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < cap_a.size()) begin
        check($sformatf("rr_type[%0d]", i), cap_a[i].typ, tbl[i].typ);
        check($sformatf("rr_vc[%0d]", i), cap_a[i].vc, tbl[i].vc);
        check($sformatf("rr_data[%0d]", i), cap_a[i].data, tbl[i].data);
        check($sformatf("rr_contig[%0d]", i), cap_cyc_a[i] - cap_cyc_a[0], i);
      end
    end
    check("rr_sb_empty", exp_a.size(), 0);
    repeat (3) @(posedge clk);
    #2 check("rr_busy_low", busy_a, 0);

    // Node 1 with seed 1: self-avoidance over 1000 packets
    push_pkts(1, 1000); en_b = 1'b1;
    for (int i = 0; i < 6000 && heads_b < 1000; i++) @(posedge clk);
    #2 en_b = 1'b0;
    for (int i = 0; i < 100 && pc_b != 16'd1000; i++) @(posedge clk);
    #2;
    check("sa_pkt_count", pc_b, 1000);
    check("sa_first_head", first_head_b, 16'h000A);
    check("sa_no_self_dest", bad_dest_b, 0);
    check("sa_sb_empty", exp_b.size(), 0);
    push_pkts(1, 1);
    @(posedge clk); #2 en_b = 1'b1;
    @(posedge clk); #2 en_b = 1'b0;
    #1 rst_b = 1'b1;
    #1 check("sa_rst_busy", busy_b, 0);
    @(posedge clk); #2 model_reset(1); rst_b = 1'b0;
    push_pkts(1, 1);
    @(posedge clk); #2 en_b = 1'b1;
    @(posedge clk); #2 en_b = 1'b0;
    for (int i = 0; i < 50 && pc_b != 16'd1; i++) @(posedge clk);
    #2;
    check("sa_fresh_count", pc_b, 1);
    check("sa_fresh_head", last_head_b, 16'h000A);
    check("sa_fresh_heads", heads_b, 1);
    check("sa_credit_err", ce_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/spidergon_traffic_injector.md
# spidergon_traffic_injector

Per-node traffic source for the spidergon NoC. Generates wormhole packets (head, body, tail flits) into one router's local input port, chooses a virtual channel per packet, and obeys credit-based flow control against that router's per-VC input buffers. One instance sits beside each node in the simulation and formal harness and replaces the bare clock/reset stimulus with real injected traffic.

## Interface
- NUM_OF_NODES, 8: ring size; power of two, at least 4; AW = log2(NUM_OF_NODES)
- FLIT_DATA_WIDTH, 16: flit payload width; must be at least 2*AW+1
- NODE_BUFFER_WIDTH, 32: bits per VC buffer; CREDITS = NODE_BUFFER_WIDTH/FLIT_DATA_WIDTH
- NUM_OF_VIRTUAL_CHANNELS, 2: VCs on the local input port; VW = max(1, clog2(NUM_OF_VIRTUAL_CHANNELS))
- NODE_ID, 0: this node's index, 0..NUM_OF_NODES-1
- PACKET_LENGTH, 4: flits per packet, head included; at least 1
- LFSR_SEED, 16'hACE1: destination LFSR reset value; must be nonzero
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  allows a new packet to start; sampled only in IDLE
- credit_in  input  NUM_OF_VIRTUAL_CHANNELS  one-cycle pulse per bit; returns one buffer slot on that VC
- flit_valid  output  1  registered; one flit is presented this cycle
- flit_type  output  2  BODY=00, HEAD=01, TAIL=10, HEAD_TAIL=11
- flit_vc  output  VW  VC carrying the flit
- flit_data  output  FLIT_DATA_WIDTH  flit payload
- busy  output  1  high whenever the FSM is in SEND
- pkt_count  output  16  packets completed; increments on tail emission; wraps
- credit_err  output  1  sticky; set by a credit returned to a VC whose counter is already at CREDITS

## Operation
- Reset values: flit_valid, flit_type, flit_vc, flit_data, busy, pkt_count and credit_err are 0. Every credit counter is CREDITS, seq is 0, rr_ptr is 0, lfsr is LFSR_SEED, and the state is IDLE.
- Credit counters: one per VC, clog2(CREDITS+1) bits wide.
  - An emitted flit decrements its VC's counter.
  - A credit_in bit increments that VC's counter.
  - A send and a return on the same VC in the same cycle leave the counter unchanged.
  - A return to a counter already at CREDITS, with no send on that VC, leaves the counter at CREDITS and sets credit_err.
- IDLE:
  - Packet start requires en=1 and at least one VC with a nonzero counter.
  - VC choice: the first VC with a nonzero counter, searching from rr_ptr upward with wrap.
  - On start, the head flit is emitted at this edge, rr_ptr becomes chosen VC+1 (mod NUM_OF_VIRTUAL_CHANNELS), lfsr advances, and the state moves to SEND with remaining = PACKET_LENGTH-1.
  - If PACKET_LENGTH=1, the head is emitted as HEAD_TAIL and the state stays IDLE (completion rules apply).
  - Otherwise flit_valid is cleared.
- Head data: bits [AW-1:0] = dest, bits [2AW-1:AW] = NODE_ID, upper bits = seq, truncated.
  - dest = lfsr[AW-1:0]; if that equals NODE_ID, dest = (NODE_ID+1) mod NUM_OF_NODES.
  - dest is never NODE_ID.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left with the feedback bit into bit 0. The value used for dest is the value before the advance.
- SEND: the packet stays on its VC, with no VC change mid-packet.
  - If that VC's counter is nonzero, the next flit is emitted and remaining decrements. The flit type is TAIL when remaining=1 and BODY otherwise.
  - If the counter is zero, flit_valid=0 (bubble) and the state holds.
- Body/tail data for flit index k (1..PACKET_LENGTH-1) is (seq*PACKET_LENGTH + k) mod 2^FLIT_DATA_WIDTH.
- Packet completion: on tail (or HEAD_TAIL) emission, pkt_count and seq increment and the state returns to IDLE.
- en=0 mid-packet has no effect; the packet always completes.
- Reset mid-packet abandons the partial packet. No tail is sent, and all counters return to CREDITS.

## Timing
- All outputs are registered. A flit is visible the cycle after the edge at which it was decided, and its counter decrement lands at that same edge.
- The credit check uses the counter value before the edge. A credit_in arriving in cycle t enables a send at the edge ending cycle t only if the counter is nonzero without it; the return counts from the next cycle.
- Start latency: en=1 in IDLE with credit puts the head on flit_valid one cycle later.
- Back-to-back packets: the tail is visible in cycle t, IDLE decides in cycle t, and the next head is visible in cycle t+1. There is no forced gap.
- Throughput: one flit per cycle per injector while credits last.
- busy rises together with the head of a multi-flit packet and falls in the cycle after the tail is visible.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately; after release with en=0 for 10 cycles -> flit_valid stays 0.
- Single packet, defaults, NODE_ID=0, en pulsed one cycle, credits returned 2 cycles after each flit:
  - flit_type sequence is HEAD, BODY, BODY, TAIL on VC0.
  - Head dest = 16'hACE1[2:0]=1, src=0, seq=0; body/tail data = 1, 2, 3.
  - pkt_count = 1.
- Credit starvation, no credit_in:
  - The head and one body are sent on VC0, then flit_valid=0 and busy=1 hold indefinitely.
  - A single credit_in[0] pulse -> exactly one more flit after one cycle of latency.
- Round robin, en held high, credits returned promptly -> packets alternate VC0, VC1, VC0; heads are contiguous with the preceding tails; seq increments 0, 1, 2.
- Credit error: credit_in[1] pulsed once after reset with no traffic -> credit_err=1 and stays 1; the VC1 counter stays at 2.
- Self-avoidance, NODE_ID=1, LFSR_SEED=16'h0001 -> first head dest = 2, never 1, over 1000 packets; a reset mid-packet then gives a fresh head with seq=0.
